// File: rtl/aes_round_seq_if.sv
// Control bundle between the AES round sequencer and its surrounding datapath/key schedule.
interface aes_round_seq_if #(
   parameter int unsigned RND_W = 4
);
   logic             start;
   logic             abort;
   logic             hold;
   logic             key_rdy;
   logic             key_req;
   logic             word_vld;
   logic [1:0]       word_idx;
   logic [RND_W-1:0] rnd_cnt;
   logic             init_rnd;
   logic             mix_bypass;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, hold, key_rdy,
      input  key_req, word_vld, word_idx, rnd_cnt, init_rnd, mix_bypass, busy, done
   );

   modport slave (
      input  start, abort, hold, key_rdy,
      output key_req, word_vld, word_idx, rnd_cnt, init_rnd, mix_bypass, busy, done
   );
endinterface

// File: rtl/aes_round_seq.sv
// AES round sequencer: per round, waits for the round key, then issues the four
// column words to the add-round-key stage; NUM_ROUNDS+1 rounds make up one block.
module aes_round_seq #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned RND_W      = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   aes_round_seq_if.slave bus_io
);

   localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      KEY_WAIT = 2'd1,
      WORDS    = 2'd2,
      DONE     = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       word_idx_q, word_idx_d;
   logic [RND_W-1:0] rnd_cnt_q, rnd_cnt_d;
   logic             key_req_q, busy_q, done_q, init_rnd_q, mix_bypass_q;
   logic             word_vld;

   // Next-state logic; abort overrides everything and wipes the counters.
   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      rnd_cnt_d  = rnd_cnt_q;
      word_vld   = 1'b0;

      if (bus_io.abort) begin
         state_d    = IDLE;
         word_idx_d = '0;
         rnd_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus_io.start) begin
                  state_d    = KEY_WAIT;
                  word_idx_d = '0;
                  rnd_cnt_d  = '0;
               end
            end
            KEY_WAIT: begin
               if (bus_io.key_rdy) state_d = WORDS;
            end
            WORDS: begin
               word_vld = !bus_io.hold;
               if (word_vld) begin
                  word_idx_d = word_idx_q + 2'd1;
                  if (word_idx_q == 2'd3) begin
                     if (rnd_cnt_q == LAST_RND) begin
                        state_d = DONE;
                     end else begin
                        rnd_cnt_d = rnd_cnt_q + RND_W'(1);
                        state_d   = KEY_WAIT;
                     end
                  end
               end
            end
            DONE: begin
               state_d    = IDLE;
               word_idx_d = '0;
               rnd_cnt_d  = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and registered outputs, the latter decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         word_idx_q   <= '0;
         rnd_cnt_q    <= '0;
         key_req_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         init_rnd_q   <= 1'b1;
         mix_bypass_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         word_idx_q   <= word_idx_d;
         rnd_cnt_q    <= rnd_cnt_d;
         key_req_q    <= (state_d == KEY_WAIT);
         busy_q       <= (state_d != IDLE);
         done_q       <= (state_d == DONE);
         init_rnd_q   <= (rnd_cnt_d == '0);
         mix_bypass_q <= (rnd_cnt_d == '0) || (rnd_cnt_d == LAST_RND);
      end
   end

   assign bus_io.key_req    = key_req_q;
   assign bus_io.word_vld   = word_vld;
   assign bus_io.word_idx   = word_idx_q;
   assign bus_io.rnd_cnt    = rnd_cnt_q;
   assign bus_io.init_rnd   = init_rnd_q;
   assign bus_io.mix_bypass = mix_bypass_q;
   assign bus_io.busy       = busy_q;
   assign bus_io.done       = done_q;

endmodule
